// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, funct3
// access-size codes and the alignment check used at request time.
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words need a multiple of four.
  // funct3[1:0]==11 is handled as a word access.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lsu_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational load extraction: picks the addressed byte/halfword
// out of the bus read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata_i  [31:0] read word from data memory
//   off_i    [1:0]  byte offset of the access
//   funct3_i [2:0]  access size (bits 1:0) and unsigned flag (bit 2)
//   data_o   [31:0] extended load result
// -----------------------------------------------------------------------------
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by sign/zero extension.
  always_comb begin
    byte_s = rdata_i[{off_i, 3'b000} +: 8];
    half_s = rdata_i[{off_i[1], 4'b0000} +: 16];
    data_o = rdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        if (funct3_i[2]) begin
          data_o = {24'h000000, byte_s};
        end else begin
          data_o = {{24{byte_s[7]}}, byte_s};
        end
      end
      2'b01: begin
        if (funct3_i[2]) begin
          data_o = {16'h0000, half_s};
        end else begin
          data_o = {{16{half_s[15]}}, half_s};
        end
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit between the single-cycle core and a gnt/rvalid data memory.
// Steers store data into byte lanes with byte enables, extends load data,
// and stalls the core until the bus access completes.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mem_rd, mem_wr       decoded load / store request (both high = store)
//   funct3               access size and sign
//   addr                 effective byte address
//   wdata                store data (rs2)
//   stall                hold PC / register-file write (combinational)
//   load_data            extended load result (registered)
//   misalign             misaligned access flagged this cycle (combinational)
//   dm_req, dm_we        bus request / write (registered)
//   dm_addr              word-aligned bus address (registered)
//   dm_wdata, dm_be      lane-steered store data and byte enables (registered)
//   dm_gnt               request accepted this cycle
//   dm_rvalid, dm_rdata  read data return
// -----------------------------------------------------------------------------
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata
);

  lsu_state_e        state_q;
  logic              dm_req_q;
  logic              dm_we_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [31:0]       dm_wdata_q;
  logic [3:0]        dm_be_q;
  logic [31:0]       load_data_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;

  logic              access_s;
  logic              mis_s;
  logic [31:0]       st_data_s;
  logic [3:0]        st_be_s;
  logic [31:0]       ld_ext_s;

  // Request qualification, stall and misalign flags. Only IDLE looks at the
  // request inputs; in DONE the same instruction is still presented.
  always_comb begin
    access_s = mem_rd | mem_wr;
    mis_s    = is_misaligned(funct3, addr[1:0]);
    stall    = 1'b0;
    misalign = 1'b0;
    case (state_q)
      ST_IDLE: begin
        misalign = access_s & mis_s;
        stall    = access_s & ~mis_s;
      end
      ST_REQ:  stall = 1'b1;
      ST_WAIT: stall = 1'b1;
      ST_DONE: stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Store lane steering: replicate the datum over the word, enable its lanes.
  always_comb begin
    st_data_s = wdata;
    st_be_s   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data_s = {4{wdata[7:0]}};
        st_be_s   = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data_s = {2{wdata[15:0]}};
        if (addr[1]) begin
          st_be_s = 4'b1100;
        end else begin
          st_be_s = 4'b0011;
        end
      end
      default: begin
        st_data_s = wdata;
        st_be_s   = 4'b1111;
      end
    endcase
  end

  // Extraction works on the latched offset/size, so both capture paths
  // (same-cycle gnt+rvalid and WAIT) see the same alignment.
  load_align u_load_align (
    .rdata_i  (dm_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ld_ext_s)
  );

  // Access FSM with registered bus outputs and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= 32'h0000_0000;
      dm_be_q     <= 4'b0000;
      load_data_q <= 32'h0000_0000;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_s && !mis_s) begin
            state_q    <= ST_REQ;
            dm_req_q   <= 1'b1;
            dm_we_q    <= mem_wr;
            dm_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            dm_wdata_q <= st_data_s;
            dm_be_q    <= mem_wr ? st_be_s : 4'b1111;
            off_q      <= addr[1:0];
            funct3_q   <= funct3;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (dm_gnt) begin
            dm_req_q <= 1'b0;
            if (dm_we_q) begin
              state_q <= ST_DONE;
            end else if (dm_rvalid) begin
              load_data_q <= ld_ext_s;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (dm_rvalid) begin
            load_data_q <= ld_ext_s;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q  <= ST_IDLE;
          dm_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dm_be     = dm_be_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Self-checking bench for dmem_lsu: directed cases plus randomized accesses
// against a behavioural model of the LSU (size/alignment arithmetic and an
// expected stall-cycle count derived from the bus response delays).
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, misalign;
  logic [31:0] load_data;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_load;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .load_data (load_data),
    .misalign  (misalign),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Reference load result from plain shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    int sz;
    sz = acc_size(f3);
    if (sz == 1) begin
      v = (w >> (8 * a[1:0])) & 32'h0000_00FF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (w >> (16 * a[1])) & 32'h0000_FFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // One core instruction: present the request right after a rising edge,
  // play the memory with the given gnt/rvalid delays, retire when stall drops.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int gdel, input int rdel);
    int          sz, stall_cnt, exp_stall, req_cnt, wait_cnt;
    logic        store, mis, granted, done;
    logic [31:0] exp_be, exp_wd;
    sz     = acc_size(f3);
    store  = wr;
    mis    = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    exp_be = 32'hF;
    if (store && sz == 1) exp_be = 32'h1 << a[1:0];
    if (store && sz == 2) exp_be = 32'h3 << (2 * a[1]);
    exp_wd = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
             (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    exp_stall = mis ? 0 : (store ? 2 + gdel : 2 + gdel + rdel);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
    granted = 1'b0; done = 1'b0;
    req_cnt = 0; wait_cnt = 0; stall_cnt = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
      if (cyc == 0) chk("misalign", misalign, mis);
      if (stall) begin
        stall_cnt++;
        if (granted) begin
          wait_cnt++;
          if (wait_cnt == rdel) begin
            dm_rvalid = 1'b1; dm_rdata = rword;
          end
        end else if (dm_req) begin
          chk("dm_addr", dm_addr, {a[31:2], 2'b00});
          chk("dm_we", dm_we, store);
          chk("dm_be", dm_be, exp_be);
          if (store) chk("dm_wdata", dm_wdata, exp_wd);
          if (req_cnt == gdel) begin
            dm_gnt = 1'b1; granted = 1'b1;
            if (!store && rdel == 0) begin
              dm_rvalid = 1'b1; dm_rdata = rword;
            end
          end else begin
            dm_rvalid = 1'($urandom_range(0, 1));
          end
          req_cnt++;
        end else begin
          dm_rvalid = 1'($urandom_range(0, 1));
        end
      end else begin
        done = 1'b1;
        chk("req_idle", dm_req, 1'b0);
        if (!mis && !store) exp_load = ref_load(f3, a, rword);
        chk("load_data", load_data, exp_load);
        chk("stall_cycles", stall_cnt, exp_stall);
        dm_rvalid = 1'($urandom_range(0, 1));
      end
    end
    chk("completed", done, 1'b1);
    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0;
  endtask

  initial begin
    logic [1:0] kind;
    rst = 1'b1;
    mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    exp_load = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dm_req, 1'b0);
    chk("rst_we", dm_we, 1'b0);
    chk("rst_addr", dm_addr, 32'h0);
    chk("rst_wdata", dm_wdata, 32'h0);
    chk("rst_be", dm_be, 4'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    do_access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);   // SB
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1);   // LB
    do_access(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1);   // LBU
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 1);   // LH, slow gnt
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h1234_5678, 0, 0);   // LW misaligned
    do_access(1'b1, 1'b1, 3'b001, 32'h0000_0044, 32'h0000_BEEF, 32'h0, 1, 0);   // rd+wr -> SH
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);   // same-cycle LW

    // Reset pulse while the load waits for rvalid.
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    chk("rw_req", dm_req, 1'b1);
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    chk("rw_wait_stall", stall, 1'b1);
    rst = 1'b1; mem_rd = 1'b0;
    #1;
    chk("rw_rst_req", dm_req, 1'b0);
    chk("rw_rst_load", load_data, 32'h0);
    chk("rw_rst_be", dm_be, 4'h0);
    chk("rw_rst_stall", stall, 1'b0);
    exp_load = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0, 0);   // SW after reset

    // Randomized accesses.
    for (int i = 0; i < 150; i++) begin
      kind = 2'($urandom_range(0, 2));
      do_access(kind != 2'd1, kind != 2'd0, 3'($urandom), $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the single-cycle core and a handshaked data memory. Takes the decoded memory request (load/store flag, funct3, ALU effective address, rs2 data), performs byte-lane steering and byte enables for stores, and sign/zero extension for loads. Stalls the core until the access completes. Its `load_data` output feeds the register-file writeback select as the memory-read source.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.

Ports (clock and reset first):
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_rd` in 1: current instruction is a load.
- `mem_wr` in 1: current instruction is a store.
- `funct3` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU; `funct3[1:0]==11` is treated as W.
- `addr` in ADDR_W: effective byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `stall` out 1: hold PC and register-file write enable.
- `load_data` out 32: extended load result (registered).
- `misalign` out 1: misaligned access flagged this cycle.
- `dm_req` out 1: bus request.
- `dm_we` out 1: write request.
- `dm_addr` out ADDR_W: word-aligned address, `[1:0]=00`.
- `dm_wdata` out 32: lane-steered store data.
- `dm_be` out 4: byte enables; all ones for loads.
- `dm_gnt` in 1: request accepted this cycle.
- `dm_rvalid` in 1: `dm_rdata` valid.
- `dm_rdata` in 32: read word.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE.
- **IDLE**, on `mem_rd|mem_wr`:
  - If aligned: register addr, funct3, we, steered wdata and be; go to REQ.
  - If both `mem_rd` and `mem_wr` are high, the access is a store.
- **Misaligned** means H with `addr[0]=1`, or W with `addr[1:0]!=0`:
  - `misalign=1` combinationally, no bus access, no stall, state stays IDLE, `load_data` holds.
- **REQ**: `dm_req=1`, payload stable until `dm_gnt`. On gnt:
  - store → DONE;
  - load with `dm_rvalid` in the same cycle → capture, DONE;
  - otherwise load → WAIT.
- **WAIT**: on `dm_rvalid`, capture the extended `dm_rdata` into `load_data` → DONE.
- **DONE**: `stall=0`, so the core retires the instruction and samples `load_data`. Request inputs are ignored (it is the same instruction); go to IDLE.
- `stall = (IDLE & (mem_rd|mem_wr) & ~misalign) | REQ | WAIT`.
- **Store steering**, with `off=addr[1:0]`:
  - SB: data `{4{wdata[7:0]}}`, be `1<<off`.
  - SH: data `{2{wdata[15:0]}}`, be `addr[1]?1100:0011`.
  - SW: data `wdata`, be `1111`.
- **Load extract**:
  - byte = `rdata[8*off+:8]`; half = `rdata[16*addr[1]+:16]`.
  - Sign-extend when `funct3[2]=0`, zero-extend when 1. Words pass through.

## Timing
- Reset: state IDLE. `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `dm_be`, `load_data` are all 0. `stall=0` and `misalign=0` while inputs are idle.
- Reset asserted mid-access drops `dm_req` immediately (async); the outstanding access is abandoned.
- Bus outputs are registered. `stall` and `misalign` are combinational from state and inputs.
- Store, zero-wait gnt: 3 cycles (IDLE, REQ, DONE).
- Load, gnt then rvalid next cycle: 4 cycles. Same-cycle gnt+rvalid: 3 cycles.
- Each extra cycle of gnt or rvalid delay adds one stall cycle. There is no timeout.
- `dm_rvalid` outside WAIT, or outside REQ-with-gnt, is ignored.
- `load_data` changes only on capture and holds through subsequent stores and idle cycles.

## Structure
- `lsu_pkg` contains:
  - the `typedef enum logic [1:0]` for IDLE/REQ/WAIT/DONE;
  - localparams for the funct3 codes (B/H/W/BU/HU);
  - the function `is_misaligned(funct3, addr[1:0])`.
- Sub-module `load_align`: purely combinational `dm_rdata` + offset + funct3 → extended 32-bit value. It is used by both the REQ-same-cycle and WAIT capture paths.

## Test plan
- SB, `addr=0x1003`, `wdata=0x000000A5`, gnt immediate → `dm_addr=0x1000`, `dm_wdata=0xA5A5A5A5`, `dm_be=1000`, `dm_we=1`, stall for 2 cycles.
- LB, `addr=0x2001`, `rdata=0x0000_80_00` → `load_data=0xFFFFFF80`; LBU on the same → `0x00000080`. Takes 4 cycles with rvalid one cycle after gnt.
- LH, `addr=0x2002`, `rdata=0x8001_1234` → `load_data=0xFFFF8001`. With gnt delayed 3 cycles, stall lasts 3 extra cycles and `dm_req` is stable throughout.
- LW, `addr=0x3002` → `misalign=1`, `dm_req` never asserts, `stall=0`, `load_data` unchanged.
- Load in REQ with `dm_gnt=dm_rvalid=1` same cycle, `rdata=0xDEADBEEF` → DONE next cycle, `load_data=0xDEADBEEF`.
- `rst` pulsed during WAIT → `dm_req=0` and state IDLE immediately, `load_data=0`. A subsequent SW, `addr=0x10`, completes normally with `be=1111`.
